// File: rtl/acc_datapath_if.sv
// Control/data bundle between the decoder-side driver and the accumulator datapath.
// The master drives the control word and operand writes; the slave returns architectural state.
interface acc_datapath_if #(
    parameter int WIDTH = 8
);
    logic [3:0]       CEO;
    logic [2:0]       ALUCode;
    logic             CE;
    logic             CY_CE;
    logic             A_CE;
    logic             in_we;
    logic [1:0]       in_sel;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] acc;
    logic             cy;
    logic             zf;
    logic [WIDTH-1:0] out_q;
    logic             sel_err;

    modport master (
        output CEO, ALUCode, CE, CY_CE, A_CE, in_we, in_sel, in_data,
        input  acc, cy, zf, out_q, sel_err
    );

    modport slave (
        input  CEO, ALUCode, CE, CY_CE, A_CE, in_we, in_sel, in_data,
        output acc, cy, zf, out_q, sel_err
    );
endinterface

// File: rtl/acc_datapath.sv
// Accumulator datapath: four operand registers, one-hot operand select, 8-op ALU,
// accumulator with carry/zero flags, output register and sticky illegal-select flag.
module acc_datapath #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    acc_datapath_if.slave bus
);
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOT  = 3'b101;
    localparam logic [2:0] OP_PASS = 3'b110;
    localparam logic [2:0] OP_ADC  = 3'b111;

    logic [WIDTH-1:0] regs [4];
    logic [WIDTH-1:0] acc_q;
    logic             cy_q;
    logic             zf_q;
    logic [WIDTH-1:0] out_q;
    logic             err_q;

    logic [WIDTH-1:0] b_bus;
    logic             multi_sel;
    logic [WIDTH:0]   alu_full;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c;

    // Zero and multi-hot selects both leave B at 0; only multi-hot is an error.
    always_comb begin
        b_bus = '0;
        case (bus.CEO)
            4'b0001: b_bus = regs[0];
            4'b0010: b_bus = regs[1];
            4'b0100: b_bus = regs[2];
            4'b1000: b_bus = regs[3];
            default: b_bus = '0;
        endcase
    end

    assign multi_sel = (bus.CEO & (bus.CEO - 4'd1)) != 4'd0;

    // Bit WIDTH of the extended result is carry-out for add and borrow for subtract.
    always_comb begin
        alu_full = '0;
        case (bus.ALUCode)
            OP_ADD:  alu_full = {1'b0, acc_q} + {1'b0, b_bus};
            OP_SUB:  alu_full = {1'b0, acc_q} - {1'b0, b_bus};
            OP_AND:  alu_full = {1'b0, acc_q & b_bus};
            OP_OR:   alu_full = {1'b0, acc_q | b_bus};
            OP_XOR:  alu_full = {1'b0, acc_q ^ b_bus};
            OP_NOT:  alu_full = {1'b0, ~acc_q};
            OP_PASS: alu_full = {1'b0, b_bus};
            OP_ADC:  alu_full = {1'b0, acc_q} + {1'b0, b_bus} + {{WIDTH{1'b0}}, cy_q};
            default: alu_full = '0;
        endcase
    end

    assign alu_res = alu_full[WIDTH-1:0];
    assign alu_c   = alu_full[WIDTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q   <= '0;
            cy_q    <= 1'b0;
            zf_q    <= 1'b1;
            out_q   <= '0;
            err_q   <= 1'b0;
            regs[0] <= '0;
            regs[1] <= '0;
            regs[2] <= '0;
            regs[3] <= '0;
        end else begin
            if (bus.A_CE) begin
                acc_q <= alu_res;
                zf_q  <= (alu_res == '0);
            end
            if (bus.CY_CE) cy_q <= alu_c;
            if (bus.CE) out_q <= acc_q;
            if (multi_sel) err_q <= 1'b1;
            // The ALU read the old value this cycle; the write lands for the next one.
            if (bus.in_we) regs[bus.in_sel] <= bus.in_data;
        end
    end

    assign bus.acc     = acc_q;
    assign bus.cy      = cy_q;
    assign bus.zf      = zf_q;
    assign bus.out_q   = out_q;
    assign bus.sel_err = err_q;
endmodule

// File: tb/tb_acc_datapath.sv
// Directed plus randomized bench for acc_datapath against an arithmetic reference model.
module tb_acc_datapath;
    localparam int W = 8;
    localparam int unsigned MOD = 1 << W;

    logic clk;
    logic rst;

    acc_datapath_if #(.WIDTH(W)) bus ();

    acc_datapath #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    int unsigned m_r [4];
    int unsigned m_acc, m_cy, m_zf, m_out, m_err;

    // Scoreboard
    logic [W-1:0] exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = 0;
        m_acc = 0; m_cy = 0; m_zf = 1; m_out = 0; m_err = 0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".acc"},     32'(bus.acc),     exp_q.pop_front());
        check({tag, ".cy"},      32'(bus.cy),      m_cy);
        check({tag, ".zf"},      32'(bus.zf),      m_zf);
        check({tag, ".out_q"},   32'(bus.out_q),   m_out);
        check({tag, ".sel_err"}, 32'(bus.sel_err), m_err);
    endtask

    // Driver: apply one control word, advance the model, check after the edge.
    task automatic step(input string tag, input logic [3:0] ceo, input logic [2:0] op,
                        input bit a_ce, input bit cy_ce, input bit ce,
                        input bit we, input int sel, input int unsigned data);
        int unsigned b, res, c, nbits;
        @(negedge clk);
        bus.CEO = ceo; bus.ALUCode = op; bus.A_CE = a_ce; bus.CY_CE = cy_ce; bus.CE = ce;
        bus.in_we = we; bus.in_sel = 2'(sel); bus.in_data = W'(data);

        nbits = $countones(ceo);
        b = 0;
        if (nbits == 1)
            for (int i = 0; i < 4; i++) if (ceo[i]) b = m_r[i];
        c = 0;
        case (op)
            3'd0: begin res = (m_acc + b) % MOD; c = (m_acc + b >= MOD) ? 1 : 0; end
            3'd1: begin res = (m_acc + MOD - b) % MOD; c = (m_acc < b) ? 1 : 0; end
            3'd2: res = m_acc & b;
            3'd3: res = m_acc | b;
            3'd4: res = m_acc ^ b;
            3'd5: res = (MOD - 1) - m_acc;
            3'd6: res = b;
            default: begin
                res = (m_acc + b + m_cy) % MOD;
                c = (m_acc + b + m_cy >= MOD) ? 1 : 0;
            end
        endcase
        if (ce) m_out = m_acc;
        if (a_ce) begin m_acc = res; m_zf = (res == 0) ? 1 : 0; end
        if (cy_ce) m_cy = c;
        if (nbits > 1) m_err = 1;
        if (we) m_r[sel] = data % MOD;
        exp_q.push_back(W'(m_acc));

        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic nop_inputs();
        bus.CEO = 4'b0000; bus.ALUCode = 3'd0; bus.A_CE = 1'b0; bus.CY_CE = 1'b0;
        bus.CE = 1'b0; bus.in_we = 1'b0; bus.in_sel = 2'd0; bus.in_data = '0;
    endtask

    initial begin
        nop_inputs();
        model_reset();
        rst = 1'b1;
        #2;
        check("reset.acc", 32'(bus.acc), 0);
        check("reset.cy", 32'(bus.cy), 0);
        check("reset.zf", 32'(bus.zf), 1);
        check("reset.out_q", 32'(bus.out_q), 0);
        check("reset.sel_err", 32'(bus.sel_err), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Accumulate sequence
        step("ld_r0", 4'b0000, 3'd0, 0, 0, 0, 1, 0, 8'h05);
        step("ld_r1", 4'b0000, 3'd0, 0, 0, 0, 1, 1, 8'h10);
        step("ld_r2", 4'b0000, 3'd0, 0, 0, 0, 1, 2, 8'h20);
        step("ld_r3", 4'b0000, 3'd0, 0, 0, 0, 1, 3, 8'h01);
        step("pass_r0", 4'b0001, 3'd6, 1, 0, 0, 0, 0, 0);
        check("pass_r0.const", 32'(bus.acc), 8'h05);
        step("add_r1", 4'b0010, 3'd0, 1, 0, 0, 0, 0, 0);
        check("add_r1.const", 32'(bus.acc), 8'h15);
        step("add_r2", 4'b0100, 3'd0, 1, 0, 0, 0, 0, 0);
        check("add_r2.const", 32'(bus.acc), 8'h35);
        step("sub_r3", 4'b1000, 3'd1, 1, 0, 0, 0, 0, 0);
        check("sub_r3.const", 32'(bus.acc), 8'h34);
        step("ce_out", 4'b0000, 3'd0, 0, 0, 1, 0, 0, 0);
        check("ce_out.const", 32'(bus.out_q), 8'h34);

        // Carry and ADC
        step("ld_r2_ff", 4'b0000, 3'd0, 0, 0, 0, 1, 2, 8'hFF);
        step("pass_ff", 4'b0100, 3'd6, 1, 0, 0, 0, 0, 0);
        step("wrap_add", 4'b1000, 3'd0, 1, 1, 0, 0, 0, 0);
        check("wrap_add.const", {bus.cy, bus.zf, 22'd0, bus.acc}, {1'b1, 1'b1, 22'd0, 8'h00});
        step("adc_r3", 4'b1000, 3'd7, 1, 0, 0, 0, 0, 0);
        check("adc_r3.const", 32'(bus.acc), 8'h02);
        step("clr_acc", 4'b0000, 3'd6, 1, 0, 0, 0, 0, 0);
        step("sub_borrow", 4'b1000, 3'd1, 1, 1, 0, 0, 0, 0);
        check("sub_borrow.const", {bus.cy, 23'd0, bus.acc}, {1'b1, 23'd0, 8'hFF});

        // Enable gating
        step("gated_add", 4'b0001, 3'd0, 0, 0, 0, 0, 0, 0);
        step("ce_with_ace", 4'b0001, 3'd6, 1, 0, 1, 0, 0, 0);
        check("ce_with_ace.const", 32'(bus.out_q), 8'hFF);

        // Illegal and empty selects
        step("illegal_sel", 4'b0110, 3'd6, 1, 0, 0, 0, 0, 0);
        check("illegal_sel.const", {bus.sel_err, 23'd0, bus.acc}, {1'b1, 23'd0, 8'h00});
        step("reload", 4'b0001, 3'd6, 1, 0, 0, 0, 0, 0);
        step("nop_sel_add", 4'b0000, 3'd0, 1, 0, 0, 0, 0, 0);
        check("nop_sel_add.const", {bus.sel_err, 23'd0, bus.acc}, {1'b1, 23'd0, 8'h05});

        // Write collision on R1
        step("clr_acc2", 4'b0000, 3'd6, 1, 0, 0, 0, 0, 0);
        step("collide", 4'b0010, 3'd0, 1, 0, 0, 1, 1, 8'h40);
        check("collide.const", 32'(bus.acc), 8'h10);
        step("after_coll", 4'b0010, 3'd0, 1, 0, 0, 0, 0, 0);
        check("after_coll.const", 32'(bus.acc), 8'h50);

        // Asynchronous reset mid-cycle
        @(posedge clk);
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        check("async_rst.acc", 32'(bus.acc), 0);
        check("async_rst.zf", 32'(bus.zf), 1);
        check("async_rst.out_q", 32'(bus.out_q), 0);
        check("async_rst.sel_err", 32'(bus.sel_err), 0);
        @(negedge clk);
        rst = 1'b0;

        // Randomized traffic
        for (int i = 0; i < 300; i++) begin
            int unsigned pick;
            logic [3:0] ceo;
            pick = $urandom_range(0, 9);
            if (pick < 8) ceo = 4'(1 << (pick % 4));
            else if (pick == 8) ceo = 4'b0000;
            else ceo = 4'($urandom_range(0, 15));
            step("rand", ceo, 3'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                 bit'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                 $urandom_range(0, MOD - 1));
            if (i == 150) begin
                @(negedge clk);
                nop_inputs();
                rst = 1'b1;
                model_reset();
                #1;
                check("rand_rst.acc", 32'(bus.acc), 0);
                check("rand_rst.sel_err", 32'(bus.sel_err), 0);
                @(negedge clk);
                rst = 1'b0;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/acc_datapath.md
# acc_datapath

Accumulator datapath that sits directly downstream of the program-memory decoder and executes the control word it emits each cycle. It holds four general operand registers R0–R3, an accumulator, a carry flag, a zero flag and an output register. A one-hot `CEO` selects the operand. The ALU combines the accumulator with that operand under `ALUCode`, and the enables `A_CE`, `CY_CE` and `CE` decide which state elements capture on the next clock edge.

## Interface
- `WIDTH`, default 8: data width of registers, ALU and output.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `CEO` in 4: one-hot operand select; bit i drives Ri onto operand bus B.
- `ALUCode` in 3: operation code from the shared defines.
- `CE` in 1: output register enable.
- `CY_CE` in 1: carry flag update enable.
- `A_CE` in 1: accumulator and zero flag update enable.
- `in_we` in 1: operand register write strobe.
- `in_sel` in 2: operand register index for write.
- `in_data` in WIDTH: operand register write data.
- `acc` out WIDTH: accumulator value.
- `cy` out 1: carry flag.
- `zf` out 1: zero flag.
- `out_q` out WIDTH: output register.
- `sel_err` out 1: sticky flag for an illegal `CEO`.

## Operation
- Operand bus B is Ri when `CEO` has exactly one bit set (bit i). For `CEO` = 0000 or any multi-bit pattern, B = 0.
- A `CEO` with more than one bit set also sets `sel_err`. `CEO` = 0000 is legal, used as a NOP, and does not set it.
- `sel_err` stays set until reset.
- ALU encodings, all WIDTH bits, result R and carry-out C:
  - ADD 000: R = A+B; C = carry out.
  - SUB 001: R = A−B mod 2^WIDTH; C = 1 when A<B (borrow).
  - AND 010, OR 011, XOR 100: bitwise; C = 0.
  - NOT 101: R = ~A; C = 0.
  - PASS 110: R = B; C = 0.
  - ADC 111: R = A+B+cy; C = carry out.
- On a clock edge:
  - `A_CE`=1: acc ← R and zf ← (R==0). Otherwise both hold.
  - `CY_CE`=1: cy ← C. Otherwise cy holds.
  - `CE`=1: out_q ← acc, using the pre-edge accumulator value. Otherwise out_q holds.
  - `in_we`=1: R[in_sel] ← in_data.
- Same-edge collision: when `in_we` targets the register selected by `CEO`, the ALU uses the old register value and the new value is visible from the next cycle.
- All enables are independent; any combination may be active on the same edge.

## Timing
- ALU and bus B are combinational from `CEO`, `ALUCode`, acc, cy and R0–R3. The result is registered with one cycle of latency; `acc`, `cy`, `zf` and `out_q` are all register outputs.
- `sel_err` is registered and asserts on the edge that samples the illegal `CEO`.
- Reset values (asynchronous, effective immediately while `rst`=1, held until the first edge after release):
  - acc = 0, cy = 0, zf = 1, out_q = 0, sel_err = 0, R0–R3 = 0.
- Reset asserted mid-operation discards any pending update on that edge.
- Width rules:
  - All arithmetic is mod 2^WIDTH with no saturation.
  - ADC uses the registered cy, not the C of the same cycle.
  - Wrap-around, e.g. 0xFF+0x01, gives acc = 0x00, cy = 1 (when `CY_CE`=1) and zf = 1.

## Test plan
- Reset check, WIDTH=8: assert `rst` asynchronously mid-cycle → acc=0, cy=0, zf=1, out_q=0 and sel_err=0 immediately.
- Accumulate sequence:
  - Setup: load R0..R3 = 0x05, 0x10, 0x20, 0x01 via `in_we`.
  - Step 1: PASS with `CEO`=0001 and `A_CE` → acc = 0x05.
  - Step 2: ADD 0010 → acc = 0x15.
  - Step 3: ADD 0100 → acc = 0x35.
  - Step 4: SUB 1000 → acc = 0x34.
  - Final: `CE` → out_q = 0x34 one cycle later.
- Carry and ADC:
  - acc = 0xFF, ADD R3 = 0x01 with `CY_CE` → acc = 0x00, cy = 1, zf = 1.
  - Next, ADC with R3 → acc = 0x02.
  - SUB 0x00 − 0x01 with `CY_CE` → acc = 0xFF, cy = 1.
- Enable gating: ADD with `A_CE`=0 and `CY_CE`=0 → acc, cy and zf unchanged. `CE` on the same edge as an `A_CE` update → out_q captures the old acc.
- Illegal select: `CEO`=0110 with PASS and `A_CE` → acc = 0x00 and sel_err = 1, and sel_err stays 1 afterwards. `CEO`=0000 → B = 0 and sel_err does not change.
- Write collision: R1 = 0x10, then `in_we` to R1 with 0x40 on the same edge as ADD with `CEO`=0010 and acc = 0 → acc = 0x10; the next ADD of R1 → acc = 0x50.
